// File: rtl/program_boot_sequencer_pkg.sv
// Shared types and defaults for the MIPS core boot sequencer.
package boot_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, HALT} boot_state_t;
  localparam logic [31:0] HALT_WORD_DEF = 32'h0000_000C;
endpackage

// File: rtl/program_boot_sequencer_if.sv
// Program-word load stream between the external programming port and the sequencer.
interface program_boot_sequencer_if #(parameter int DATA_W = 32);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/program_boot_sequencer_watchdog.sv
// RUN cycle counter; saturates at MAX_CYCLES-1 and flags expiry at that value.
module run_watchdog #(
  parameter int MAX_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == LAST);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (en && !expired) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/program_boot_sequencer.sv
// Loads program words into imu, runs the core out of reset, and parks it on halt,
// timeout, or load overflow.
module program_boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(HALT_WORD_DEF),
  parameter int                MAX_CYCLES = 4096,
  parameter int                CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  program_boot_sequencer_if.slave ld,
  output logic                   imu_wen,
  output logic [ADDR_W-1:0]      imu_addr,
  output logic [DATA_W-1:0]      imu_data,
  input  logic [DATA_W-1:0]      instr,
  output logic                   core_clr,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W:0]        word_count,
  output logic [CNT_W-1:0]       cycle_count
);
  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              core_clr_q, core_clr_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              xfer, is_halt, wd_expired, wd_clr, wd_en;

  assign ld.load_ready = (state_q == LOAD);
  assign xfer          = ld.load_valid && (state_q == LOAD);
  assign is_halt       = (instr == HALT_WORD);

  // Counter restarts in RELEASE and only advances on cycles that stay in RUN,
  // so it freezes at the value seen in the final RUN cycle.
  assign wd_clr = clr || (state_q == RELEASE);
  assign wd_en  = (state_q == RUN) && (state_d == RUN);

  run_watchdog #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) u_wdog (
    .clk     (clk),
    .clr     (wd_clr),
    .en      (wd_en),
    .count   (cycle_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: if (start) state_d = LOAD;
      LOAD: begin
        if (xfer) begin
          if (ld.load_last)   state_d = RELEASE;
          else if (wp_q == '1) state_d = HALT;
        end
      end
      RELEASE: state_d = RUN;
      RUN:     if (is_halt || wd_expired) state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wp_d       = wp_q;
    wc_d       = wc_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    error_d    = error_q;
    core_clr_d = (state_d != RUN);
    if ((state_q == IDLE || state_q == HALT) && start) begin
      wp_d    = '0;
      wc_d    = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (xfer) begin
      wen_d  = 1'b1;
      addr_d = wp_q;
      data_d = ld.load_data;
      wp_d   = wp_q + 1'b1;
      wc_d   = wc_q + 1'b1;
    end
    // Entering HALT from LOAD is always an overflow; from RUN a halt word beats timeout.
    if (state_q != HALT && state_d == HALT) begin
      done_d  = 1'b1;
      error_d = (state_q == LOAD) || !is_halt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp_q       <= '0;
      wc_q       <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_clr_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      wc_q       <= wc_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_clr_q <= core_clr_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign imu_wen    = wen_q;
  assign imu_addr   = addr_q;
  assign imu_data   = data_q;
  assign core_clr   = core_clr_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_program_boot_sequencer.sv
// Randomized scoreboard bench for program_boot_sequencer with a program-level reference model.
module tb_program_boot_sequencer;
  localparam int ADDR_W = 2, DATA_W = 32, MAXC = 16, CNT_W = 5, DEPTH = 1 << ADDR_W;
  localparam logic [31:0] HW = 32'h0000_000C;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic err; int cc; int wc; } res_t;

  logic              clk = 1'b0, clr = 1'b1, start = 1'b0;
  logic [31:0]       instr = '0;
  logic              imu_wen, core_clr, done, error;
  logic [ADDR_W-1:0] imu_addr;
  logic [31:0]       imu_data;
  logic [ADDR_W:0]   word_count;
  logic [CNT_W-1:0]  cycle_count;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  wr_t  mw;
  res_t mr;
  int   vectors = 0, errors = 0, prev_cc = 0;
  logic done_seen = 1'b0;

  always #5 clk = ~clk;

  program_boot_sequencer_if #(.DATA_W(DATA_W)) ld_if ();

  program_boot_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_WORD(HW), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .ld(ld_if),
    .imu_wen(imu_wen), .imu_addr(imu_addr), .imu_data(imu_data), .instr(instr),
    .core_clr(core_clr), .done(done), .error(error),
    .word_count(word_count), .cycle_count(cycle_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] nonhalt();
    logic [31:0] v;
    v = $urandom;
    if (v == HW) v = v ^ 32'h1;
    return v;
  endfunction

  // Monitor: every imu write and every rising done is matched against the model's queues.
  always @(negedge clk) begin
    if (imu_wen === 1'b1) begin
      if (exp_wr.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", imu_addr, imu_data);
      end else begin
        mw = exp_wr.pop_front();
        chk("wr_addr", 64'(imu_addr), 64'(mw.addr));
        chk("wr_data", 64'(imu_data), 64'(mw.data));
      end
    end
    if (done === 1'b1 && done_seen !== 1'b1) begin
      if (exp_res.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_done: got done=1, expected done=0");
      end else begin
        mr = exp_res.pop_front();
        chk("res_error", 64'(error), 64'(mr.err));
        chk("res_cycle_count", 64'(cycle_count), 64'(mr.cc));
        chk("res_word_count", 64'(word_count), 64'(mr.wc));
        chk("res_core_clr", 64'(core_clr), 64'd1);
      end
    end
    done_seen = done;
  end

  task automatic do_reset();
    clr = 1'b1; start = 1'b0; ld_if.load_valid = 1'b0; ld_if.load_last = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_imu_wen", 64'(imu_wen), 64'd0);
    chk("rst_imu_addr", 64'(imu_addr), 64'd0);
    chk("rst_imu_data", 64'(imu_data), 64'd0);
    chk("rst_core_clr", 64'(core_clr), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("rst_load_ready", 64'(ld_if.load_ready), 64'd0);
    clr = 1'b0;
    exp_wr.delete(); exp_res.delete(); prev_cc = 0;
  endtask

  // lastpos<0 or >=DEPTH: overflow. mode 0 back-to-back, 1 alternating, 2 random gaps.
  // h: RUN cycle (1-based) carrying HALT_WORD, 0 = never. ab_*: reset point, -1 = none.
  task automatic do_program(input int lastpos, input int mode, input int h,
                            input int ab_load, input int ab_run);
    int   nacc, acc, it, k;
    bit   ovf;
    res_t r;
    wr_t  w;
    ovf  = (lastpos < 0) || (lastpos >= DEPTH);
    nacc = ovf ? DEPTH : lastpos + 1;
    r.wc = nacc;
    if (ovf)                       begin r.err = 1'b1; r.cc = prev_cc; end
    else if (h >= 1 && h <= MAXC)  begin r.err = 1'b0; r.cc = h - 1;   end
    else                           begin r.err = 1'b1; r.cc = MAXC - 1; end
    prev_cc = r.cc;
    exp_res.push_back(r);

    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_done", 64'(done), 64'd0);
    chk("start_error", 64'(error), 64'd0);
    chk("start_word_count", 64'(word_count), 64'd0);
    chk("start_load_ready", 64'(ld_if.load_ready), 64'd1);

    acc = 0; it = 0;
    while (acc < nacc && it < 200) begin
      if (it == ab_load) begin do_reset(); return; end
      if ((mode == 1 && it % 2 == 1) || (mode == 2 && $urandom_range(0, 99) < 30)) begin
        ld_if.load_valid = 1'b0;
        ld_if.load_last  = 1'($urandom_range(0, 1));
        ld_if.load_data  = $urandom;
        if (mode == 1) chk("ready_without_valid", 64'(ld_if.load_ready), 64'd1);
      end else begin
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = $urandom;
        ld_if.load_last  = (acc == lastpos);
        if (ld_if.load_ready === 1'b1) begin
          w.addr = acc[ADDR_W-1:0];
          w.data = ld_if.load_data;
          exp_wr.push_back(w);
          acc++;
        end
      end
      start = ($urandom_range(0, 4) == 0);
      instr = nonhalt();
      @(negedge clk);
      it++;
    end
    ld_if.load_valid = 1'b0; ld_if.load_last = 1'b0; start = 1'b0;
    chk("load_accepted", 64'(acc), 64'(nacc));
    if (acc < nacc || ovf) return;

    chk("release_core_clr", 64'(core_clr), 64'd1);
    @(negedge clk);
    chk("run_core_clr", 64'(core_clr), 64'd0);
    k = 0;
    while (core_clr === 1'b0 && k < MAXC + 4) begin
      k++;
      if (k == ab_run) begin do_reset(); return; end
      instr = (k == h) ? HW : nonhalt();
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    instr = nonhalt(); start = 1'b0;
    chk("run_length", 64'(k), 64'(r.cc + 1));
  endtask

  initial begin
    int lp, md, hh, al, ar;
    ld_if.load_valid = 1'b0; ld_if.load_last = 1'b0; ld_if.load_data = '0;
    do_reset();
    do_program(2, 0, 5, -1, -1);
    do_program(1, 1, 10, -1, -1);
    repeat (3) @(negedge clk);
    chk("halt_cycle_frozen", 64'(cycle_count), 64'd9);
    chk("halt_words_frozen", 64'(word_count), 64'd2);
    do_program(0, 0, 0, -1, -1);
    do_program(3, 2, 16, -1, -1);
    do_program(-1, 0, 0, -1, -1);
    repeat (2) @(negedge clk);
    chk("ovf_core_clr_held", 64'(core_clr), 64'd1);
    do_program(1, 0, 3, -1, -1);
    do_program(2, 0, 1, -1, -1);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      lp = $urandom_range(0, 5);
      if (lp == 5) lp = -1;
      md = $urandom_range(0, 2);
      hh = $urandom_range(0, 20);
      al = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      ar = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : -1;
      do_program(lp, md, hh, al, ar);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("results_outstanding", 64'(exp_res.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
